// File: rtl/sap_program_counter.sv
// ---------------------------------------------------------------------------
// sap_program_counter
//
// Program counter for the 16-bit SAP CPU. Holds the address of the next
// instruction. It is loaded from the shared system bus on jumps and advanced
// by STEP after each fetch.
//
// Priority per rising edge (rst high): [pc_restore] > pc_write > pc_inc > hold
//
// Ports:
//   clk        in   1      system clock, rising-edge active
//   rst        in   1      asynchronous reset, active-low
//   pc_write   in   1      load pc from bus on next rising edge
//   pc_inc     in   1      advance pc by STEP on next rising edge
//   bus        in   WIDTH  load / jump target
//   pc_save    in   1      (PC_SHADOW_EN only) copy resolved next pc to shadow
//   pc_restore in   1      (PC_SHADOW_EN only) reload pc from shadow
//   pc_out     out  WIDTH  current program counter, registered
//   pc_wrap    out  1      one-cycle pulse after an increment rolls over
//
// Optional feature macro: PC_SHADOW_EN (shadow register for interrupt
// entry/return). When undefined the shadow ports and register do not exist.
// ---------------------------------------------------------------------------
module sap_program_counter #(
    parameter int unsigned WIDTH       = 16,
    parameter logic [15:0] RESET_VALUE = 16'h0000,
    parameter int unsigned STEP        = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_write,
    input  logic             pc_inc,
    input  logic [WIDTH-1:0] bus,
`ifdef PC_SHADOW_EN
    input  logic             pc_save,
    input  logic             pc_restore,
`endif
    output logic [WIDTH-1:0] pc_out,
    output logic             pc_wrap
);

    // Reset value truncated (or zero-extended) to the register width.
    localparam logic [WIDTH-1:0] RST_VAL  = WIDTH'(RESET_VALUE);
    // Step widened by one bit so the carry out of the top bit is visible.
    localparam logic [WIDTH:0]   STEP_EXT = (WIDTH + 1)'(STEP);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic             wrap_q;
    logic             wrap_d;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] resolved_s;
    logic             resolved_wrap_s;

    // Incrementer with carry-out; the top bit is the roll-over indication.
    assign sum_s = {1'b0, pc_q} + STEP_EXT;

    // Load / increment / hold resolution, before any shadow override.
    always_comb begin
        resolved_s      = pc_q;
        resolved_wrap_s = 1'b0;
        if (pc_write == 1'b1) begin
            resolved_s      = bus;
            resolved_wrap_s = 1'b0;
        end else if (pc_inc == 1'b1) begin
            resolved_s      = sum_s[WIDTH-1:0];
            resolved_wrap_s = sum_s[WIDTH];
        end else begin
            resolved_s      = pc_q;
            resolved_wrap_s = 1'b0;
        end
    end

`ifdef PC_SHADOW_EN
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] shadow_d;

    // Restore overrides everything; save captures the value pc takes this
    // edge, but a simultaneous restore leaves the shadow untouched.
    always_comb begin
        pc_d     = resolved_s;
        wrap_d   = resolved_wrap_s;
        shadow_d = shadow_q;
        if (pc_restore == 1'b1) begin
            pc_d     = shadow_q;
            wrap_d   = 1'b0;
            shadow_d = shadow_q;
        end else if (pc_save == 1'b1) begin
            shadow_d = resolved_s;
        end else begin
            shadow_d = shadow_q;
        end
    end

    // Shadow register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_q <= RST_VAL;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`else
    // No shadow: next state is the plain load/increment/hold result.
    always_comb begin
        pc_d   = resolved_s;
        wrap_d = resolved_wrap_s;
    end
`endif

    // Program counter and wrap-pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q   <= RST_VAL;
            wrap_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            wrap_q <= wrap_d;
        end
    end

    assign pc_out  = pc_q;
    assign pc_wrap = wrap_q;

endmodule

// File: tb/tb_sap_program_counter.sv
// ---------------------------------------------------------------------------
// tb_sap_program_counter
//
// Directed bench for sap_program_counter (WIDTH=16, RESET_VALUE=0, STEP=1).
// A driver applies one vector per cycle at the falling edge and pushes the
// hand-computed expected {pc_wrap, pc_out} into a queue; a monitor pops and
// compares shortly after each rising edge. Asynchronous reset is checked
// directly between edges.
// ---------------------------------------------------------------------------
module tb_sap_program_counter;

    logic        clk;
    logic        rst;
    logic        pc_write;
    logic        pc_inc;
    logic [15:0] bus;
    logic        pc_save;
    logic        pc_restore;
    logic [15:0] pc_out;
    logic        pc_wrap;

    int checks;
    int fails;

    logic [16:0] exp_q[$];

    sap_program_counter #(
        .WIDTH      (16),
        .RESET_VALUE(16'h0000),
        .STEP       (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pc_write  (pc_write),
        .pc_inc    (pc_inc),
        .bus       (bus),
`ifdef PC_SHADOW_EN
        .pc_save   (pc_save),
        .pc_restore(pc_restore),
`endif
        .pc_out    (pc_out),
        .pc_wrap   (pc_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected response per rising edge that had a vector.
    always @(posedge clk) begin
        logic [16:0] e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks = checks + 1;
            if ({pc_wrap, pc_out} !== e) begin
                fails = fails + 1;
                $display("FAIL edge-check t=%0t: got pc=%h wrap=%b, expected pc=%h wrap=%b",
                         $time, pc_out, pc_wrap, e[15:0], e[16]);
            end
        end
    end

    task automatic step(input logic r, input logic w, input logic i,
                        input logic sv, input logic rs, input logic [15:0] b,
                        input logic [15:0] exp_pc, input logic exp_wrap);
        @(negedge clk);
        rst        = r;
        pc_write   = w;
        pc_inc     = i;
        pc_save    = sv;
        pc_restore = rs;
        bus        = b;
        exp_q.push_back({exp_wrap, exp_pc});
    endtask

    // Assert reset between edges and check that outputs clear at once.
    task automatic async_reset_check(input string name);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checks = checks + 1;
        if (pc_out !== 16'h0000 || pc_wrap !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL %s: got pc=%h wrap=%b, expected pc=0000 wrap=0",
                     name, pc_out, pc_wrap);
        end
    endtask

    initial begin
        checks     = 0;
        fails      = 0;
        rst        = 1'b0;
        pc_write   = 1'b0;
        pc_inc     = 1'b0;
        pc_save    = 1'b0;
        pc_restore = 1'b0;
        bus        = 16'h0000;

        //    rst   wr    inc   sv    rs    bus       pc        wrap
        // Reset held while a load is requested
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000, 1'b0);
        // Load after release, then hold
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0005, 16'h0005, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0005, 16'h0005, 1'b0);
        // Increment twice, then hold
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0006, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0007, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0007, 1'b0);
        // Load beats increment
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h00A0, 16'h00A0, 1'b0);
        // Wrap: pulse lasts one cycle, next inc gives 0001
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0001, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, 1'b0);
        // Wrap then hold: pulse drops; load on the wrap edge never wraps
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        // Async reset while the wrap pulse is high
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        async_reset_check("async-reset-wrap");
        // Async reset with a nonzero pc, pending load overridden
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h1234, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h4321, 16'h4321, 1'b0);
        async_reset_check("async-reset-pc");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h7777, 16'h0000, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h7777, 16'h0001, 1'b0);

`ifdef PC_SHADOW_EN
        // Save captures post-increment value; restore beats load
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0010, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0010, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0200, 16'h0200, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0010, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0011, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0300, 16'h0300, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0400, 16'h0011, 1'b0);
        // Save and restore together: shadow keeps 0011
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0500, 16'h0500, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0600, 16'h0011, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0700, 16'h0700, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0011, 1'b0);
        // Restore right after wrap clears the pulse
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0011, 1'b0);
`endif

        @(negedge clk);
        pc_write   = 1'b0;
        pc_inc     = 1'b0;
        pc_save    = 1'b0;
        pc_restore = 1'b0;

        // Bounded drain of the scoreboard.
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            checks = checks + 1;
            fails  = fails + 1;
            $display("FAIL drain: %0d responses never observed, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/sap_program_counter.md
Name: sap_program_counter

Overview:
- Program counter for the 16-bit SAP CPU: a WIDTH-bit register holding the address of the next instruction.
- Loaded from the shared system bus on jumps (pc_write) and incremented after each fetch (pc_inc).
- pc_out feeds the memory address path and the control unit.
- A one-cycle wrap flag flags address-space roll-over.

Parameters:
- WIDTH, 16, register, bus and output width in bits.
- RESET_VALUE, 16'h0000, value loaded by reset; truncated to WIDTH.
- STEP, 1, amount added per pc_inc; must be in 1..2**WIDTH-1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous reset, active-low (asserted when 0).
- pc_write  input  1  load pc from bus on next rising edge.
- pc_inc  input  1  advance pc by STEP on next rising edge.
- bus  input  WIDTH  system bus value used as load/jump target.
- pc_out  output  WIDTH  current program counter value, registered.
- pc_wrap  output  1  registered pulse: high for one cycle after an increment rolls past 2**WIDTH-1.

Behaviour:
Clocking and reset:
- Single clock domain.
- Reset is asynchronous and active-low: rst=0 immediately forces pc_out=RESET_VALUE and pc_wrap=0, independent of clk.
- Reset release is sampled synchronously; the first update occurs on the first rising edge with rst=1.
- Reset asserted mid-operation overrides any pending load or increment.

Per rising edge with rst=1, priority pc_write > pc_inc > hold:
- pc_write=1: pc_out <= bus. pc_inc is ignored in that cycle. pc_wrap <= 0.
- pc_write=0, pc_inc=1: pc_out <= (pc_out + STEP) mod 2**WIDTH. pc_wrap <= 1 iff the unsigned sum carried out of bit WIDTH-1, else 0.
- Both 0: pc_out holds. pc_wrap <= 0.

Timing and widths:
- Latency: one clock from control sampled high to new pc_out visible. No combinational path from inputs to outputs.
- Continuous pc_inc advances by STEP every cycle.
- Wrap-around example: pc_out=16'hFFFF with pc_inc (STEP=1) gives 16'h0000 and pc_wrap=1 for exactly one cycle.
- bus must be exactly WIDTH bits. No sign extension, no X-propagation tricks; unknown controls are not decoded as valid.

Optional Feature:
- Macro: PC_SHADOW_EN.
- When defined, adds inputs pc_save (1) and pc_restore (1) and a WIDTH-bit shadow register, reset to RESET_VALUE. The shadow register is used for interrupt entry and return.
- pc_save=1 at an edge: shadow <= value pc_out takes at that same edge, after load/inc resolution.
- pc_restore=1: pc_out <= shadow, with highest priority over pc_write and pc_inc. pc_wrap <= 0.
- Simultaneous save and restore: restore wins and shadow is unchanged.
- When undefined: the ports and shadow register do not exist, and behaviour is exactly as above.

Test Plan:
- Reset: hold rst=0 while pc_write=1, bus=16'h1234 across edges -> pc_out stays 16'h0000, pc_wrap=0. Asserting rst mid-cycle clears pc_out immediately, without waiting for a clock edge.
- Load: after reset release, bus=16'h0005, pc_write=1 for one edge -> pc_out=16'h0005 after that edge. Dropping pc_write holds 16'h0005.
- Increment: from 16'h0005, pc_inc=1 for two edges -> 16'h0006 then 16'h0007. pc_inc=0 holds 16'h0007.
- Priority: pc_write=1 and pc_inc=1 together with bus=16'h00A0 -> pc_out=16'h00A0, not 16'h00A1.
- Wrap: load 16'hFFFF, then pc_inc one edge -> pc_out=16'h0000 and pc_wrap=1 for one cycle. A further inc gives 16'h0001 with pc_wrap=0.
- Shadow (PC_SHADOW_EN): at pc=16'h0010, pulse pc_save, load 16'h0200, then pulse pc_restore -> pc_out returns to 16'h0010.
